// File: rtl/circuit2_seq.sv
// Multi-cycle Circuit_2: one shared adder computes d, e and f in turn, then a
// single compare/select/shift step produces the registered x and z results.
module circuit2_seq #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  output logic [DATAWIDTH-1:0] x,
  output logic [DATAWIDTH-1:0] z,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_D = 3'd1,
    LD_E = 3'd2,
    LD_F = 3'd3,
    CMP  = 3'd4,
    WB   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [DATAWIDTH-1:0] a_r, b_r, c_r;
  logic [DATAWIDTH-1:0] d_r, e_r, f_r, g_r, h_r;
  logic                 lt_r, eq_r;

  logic [DATAWIDTH-1:0] alu_opb;
  logic                 alu_cin;
  logic [DATAWIDTH-1:0] alu_sum;
  logic                 cmp_lt, cmp_eq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Encodings 6 and 7 fall into the default arm and recover to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? LD_D : IDLE;
      LD_D:    state_nxt = LD_E;
      LD_E:    state_nxt = LD_F;
      LD_F:    state_nxt = CMP;
      CMP:     state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    alu_opb = b_r;
    alu_cin = 1'b0;
    case (state)
      LD_D: begin busy = 1'b1; alu_opb = b_r; end
      LD_E: begin busy = 1'b1; alu_opb = c_r; end
      LD_F: begin busy = 1'b1; alu_opb = ~b_r; alu_cin = 1'b1; end
      CMP:  busy = 1'b1;
      WB:   busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Subtraction is a + ~b + 1; the carry out of the top bit is dropped.
  assign alu_sum = a_r + alu_opb + {{(DATAWIDTH-1){1'b0}}, alu_cin};
  assign cmp_lt  = (d_r < e_r);
  assign cmp_eq  = (d_r == e_r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= '0;
      d_r  <= '0;
      e_r  <= '0;
      f_r  <= '0;
      g_r  <= '0;
      h_r  <= '0;
      lt_r <= 1'b0;
      eq_r <= 1'b0;
      x    <= '0;
      z    <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == WB);
      case (state)
        IDLE: if (start) begin
          a_r <= a;
          b_r <= b;
          c_r <= c;
        end
        LD_D: d_r <= alu_sum;
        LD_E: e_r <= alu_sum;
        LD_F: f_r <= alu_sum;
        CMP: begin
          lt_r <= cmp_lt;
          eq_r <= cmp_eq;
          g_r  <= cmp_lt ? e_r : d_r;
          h_r  <= cmp_eq ? f_r : (cmp_lt ? e_r : d_r);
        end
        WB: begin
          x <= lt_r ? {g_r[DATAWIDTH-2:0], 1'b0} : g_r;
          z <= eq_r ? {1'b0, h_r[DATAWIDTH-1:1]} : h_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_circuit2_seq.sv
// Directed bench for circuit2_seq: reset, each compare path, wrap-around and
// the start/reset protocol corner cases, with hand-computed expected values.
module tb_circuit2_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b, c;
  logic [31:0] x, z;
  logic        busy, done;

  int tests = 0;
  int fails = 0;

  circuit2_seq #(.DATAWIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
    .x(x), .z(z), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle, then wait (bounded) for done.
  // lat = edges after E0 until done is seen; allbusy = busy held until done.
  task automatic run_op(input logic [31:0] va, vb, vc,
                        output int lat, output bit allbusy);
    @(negedge clk);
    a = va; b = vb; c = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    allbusy = 1'b1;
    while (!done && lat < 20) begin
      if (!busy) allbusy = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy) allbusy = 1'b0;
  endtask

  task automatic test_reset;
    int dcnt;
    rst = 1'b0; start = 1'b0; a = '0; b = '0; c = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (x !== 32'd0 || z !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_vals: x=%h z=%h busy=%b done=%b required all 0", x, z, busy, done);
    end
    rst = 1'b1;
    dcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    tests++;
    if (dcnt !== 0 || busy !== 1'b0 || x !== 32'd0 || z !== 32'd0) begin
      fails++;
      $display("FAIL idle: done_cnt=%0d busy=%b x=%h z=%h required 0/0/0/0", dcnt, busy, x, z);
    end
  endtask

  task automatic test_lt_path;
    int lat; bit ab;
    run_op(32'd5, 32'd3, 32'd10, lat, ab);
    tests++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL lt_latency: got %0d edges required 5", lat);
    end
    tests++;
    if (x !== 32'h1E || z !== 32'hF) begin
      fails++;
      $display("FAIL lt_result: x=%h z=%h required 0000001e 0000000f", x, z);
    end
    tests++;
    if (!ab) begin
      fails++;
      $display("FAIL lt_busy: busy profile wrong, required 1 through E4 and 0 at done");
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: done=%b one cycle later required 0", done);
    end
  endtask

  task automatic test_eq_path;
    int lat; bit ab;
    run_op(32'd4, 32'd6, 32'd6, lat, ab);
    tests++;
    if (lat !== 5 || x !== 32'd10 || z !== 32'h7FFFFFFF) begin
      fails++;
      $display("FAIL eq_result: lat=%0d x=%h z=%h required 5 0000000a 7fffffff", lat, x, z);
    end
  endtask

  task automatic test_gt_operand_change;
    int lat;
    @(negedge clk);
    a = 32'd9; b = 32'd7; c = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0; c = '0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (lat !== 5 || x !== 32'd16 || z !== 32'd16) begin
      fails++;
      $display("FAIL gt_change: lat=%0d x=%h z=%h required 5 00000010 00000010", lat, x, z);
    end
  endtask

  task automatic test_wrap;
    int lat; bit ab;
    run_op(32'hFFFFFFFF, 32'd2, 32'd0, lat, ab);
    tests++;
    if (lat !== 5 || x !== 32'hFFFFFFFE || z !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL wrap: lat=%0d x=%h z=%h required 5 fffffffe ffffffff", lat, x, z);
    end
  endtask

  task automatic test_start_while_busy;
    int dcnt;
    @(negedge clk);
    a = 32'd5; b = 32'd3; c = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    // Sampled at E2 with different operands; must be ignored entirely.
    start = 1'b1; a = 32'd1; b = 32'd1; c = 32'd1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    tests++;
    if (dcnt !== 1 || x !== 32'h1E || z !== 32'hF) begin
      fails++;
      $display("FAIL busy_start: done_cnt=%0d x=%h z=%h required 1 0000001e 0000000f", dcnt, x, z);
    end
  endtask

  task automatic test_reset_mid_op;
    int dcnt, lat; bit ab;
    @(negedge clk);
    a = 32'd4; b = 32'd6; c = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (x !== 32'd0 || z !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_reset: x=%h z=%h busy=%b done=%b required all 0", x, z, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    dcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    tests++;
    if (dcnt !== 0 || x !== 32'd0) begin
      fails++;
      $display("FAIL abort_nodone: done_cnt=%0d x=%h required 0 00000000", dcnt, x);
    end
    run_op(32'd9, 32'd7, 32'd2, lat, ab);
    tests++;
    if (lat !== 5 || !ab || x !== 32'd16 || z !== 32'd16) begin
      fails++;
      $display("FAIL after_abort: lat=%0d busy_ok=%b x=%h z=%h required 5 1 00000010 00000010",
               lat, ab, x, z);
    end
  endtask

  task automatic test_back_to_back;
    int dcnt, prev, bad;
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'd2; c = 32'd0; start = 1'b1;
    dcnt = 0; prev = -1; bad = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (prev >= 0 && cyc - prev != 6) bad++;
        if (x !== 32'hFFFFFFFE || z !== 32'hFFFFFFFF) bad++;
        prev = cyc;
        dcnt++;
      end
    end
    start = 1'b0;
    tests++;
    if (dcnt < 6 || bad !== 0) begin
      fails++;
      $display("FAIL back_to_back: done_cnt=%0d bad=%0d required >=6 and 0", dcnt, bad);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_lt_path;
    test_eq_path;
    test_gt_operand_change;
    test_wrap;
    test_start_while_busy;
    test_reset_mid_op;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/circuit2_seq.md
Name: circuit2_seq

Overview:
- Multi-cycle, resource-shared implementation of the Circuit_2 function.
- A start/done FSM time-multiplexes one adder/subtractor over the three arithmetic ops (d, e, f), then runs one compare/select/shift step.
- Used where area outweighs throughput; the register outputs x and z match the combinational-plus-REG version for the same a, b, c.

Parameters:
- DATAWIDTH, 32, width of operands, intermediates and results.

Ports:
- clk    in   1          rising-edge clock
- rst    in   1          asynchronous, active-low reset (0 = reset)
- start  in   1          request; sampled only in IDLE
- a      in   DATAWIDTH  operand a, unsigned
- b      in   DATAWIDTH  operand b, unsigned
- c      in   DATAWIDTH  operand c, unsigned
- x      out  DATAWIDTH  registered result x
- z      out  DATAWIDTH  registered result z
- busy   out  1          1 while an operation is in progress
- done   out  1          one-cycle pulse when x and z update

Behaviour:
- Reset (rst=0, async): state=IDLE; x=0, z=0, busy=0, done=0; operand and intermediate registers = 0.
- Function (all unsigned, modulo 2^DATAWIDTH):
  - d=a+b; e=a+c; f=a-b.
  - lt=(d<e); eq=(d==e).
  - g = lt ? e : d.
  - h = eq ? f : g.
  - x = g << lt; z = h >> eq (logical shifts, shift amount 0 or 1).
- Shared ALU: one DATAWIDTH adder.
  - Operand B mux selects b, c or ~b.
  - Carry-in is 1 only for the f step.
  - Carry-out is discarded.
- One comparator, used only in CMP.
- FSM: IDLE -> LD_D -> LD_E -> LD_F -> CMP -> WB -> IDLE.
  - Edge E0 (IDLE, start=1): latch a, b, c into operand regs; -> LD_D; busy<=1.
  - IDLE with start=0: stay in IDLE.
  - E1 (LD_D): d_r <= a_r+b_r; -> LD_E.
  - E2 (LD_E): e_r <= a_r+c_r; -> LD_F.
  - E3 (LD_F): f_r <= a_r-b_r; -> CMP.
  - E4 (CMP): lt_r, eq_r, g_r, h_r registered; -> WB.
  - E5 (WB): x <= g_r<<lt_r; z <= h_r>>eq_r; done<=1; busy<=0; -> IDLE.
  - E6: done<=0.
- Latency: x, z and done are valid after E5 (5 edges after start is sampled). done is high for exactly one cycle.
- Throughput: one result per 6 cycles. Start held continuously is accepted again at E6, in the IDLE cycle where done=1.
- start while busy=1: ignored. It is not queued, and operand regs stay unchanged.
- a, b, c may change after E0 with no effect on the current operation.
- x and z hold their last result until the next WB edge. They are not cleared on start.
- Reset asserted mid-operation: immediate return to the reset values. No done pulse. The aborted operation is lost.
- Only the listed states are reachable. Any illegal encoding -> IDLE on the next edge with busy=0 and done=0.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release, start=0 for 10 cycles -> x=0, z=0, busy=0, done never 1.
- lt path: a=5, b=3, c=10, start pulse -> d=8, e=15, f=2, lt=1; done at E5 with x=30 (0x1E), z=15 (0xF); busy high E0..E5 only.
- eq path: a=4, b=6, c=6 -> d=e=10, f=0xFFFFFFFE; x=10, z=0x7FFFFFFF.
- gt path plus operand change: a=9, b=7, c=2, then drive a=b=c=0 right after E0 -> x=16, z=16, unaffected by the change.
- wrap-around: a=0xFFFFFFFF, b=2, c=0 -> d=1, e=0xFFFFFFFF, f=0xFFFFFFFD; x=0xFFFFFFFE, z=0xFFFFFFFF.
- Protocol: start re-pulsed at E2 -> ignored, single done. rst=0 at E3 -> outputs 0 with no done; next start runs a full 6-cycle operation correctly. start held high -> done pulses every 6 cycles.
